addsub_arbiter: RTL and testbench

- Shares one 8-bit two's-complement add/subtract unit between two requesters using valid/ready handshakes and round-robin arbitration.
- Sequences each operation through issue, execute and respond phases.
- Returns the result, carry, overflow and requester ID.
- Keeps a saturating count of overflowing operations for status readback.

---
 rtl/addsub_pkg.sv | 16 +
 rtl/addsub_core.sv | 39 +++
 rtl/addsub_arbiter.sv | 113 +++++++++++
 tb/tb_addsub_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract arbiter and its core.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;

endpackage

// File: rtl/addsub_core.sv
// Combinational two's-complement add/subtract with carry and signed overflow.
// Optional clamping of overflowed results is enabled by ADDSUB_SATURATE_EN.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf
);

`ifdef ADDSUB_SATURATE_EN
  // Package constants are 8 bits; replicate their low bits so the clamp tracks WIDTH.
  localparam logic [WIDTH-1:0] SAT_P = {SAT_POS[7], {(WIDTH-1){SAT_POS[0]}}};
  localparam logic [WIDTH-1:0] SAT_N = {SAT_NEG[7], {(WIDTH-1){SAT_NEG[0]}}};
`endif

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] sum;
  logic             cin;

  always_comb begin
    bx  = (op == OP_ADD) ? b : ~b;
    cin = (op == OP_SUB);
    {cout, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`ifdef ADDSUB_SATURATE_EN
    if (ovf) res = a[WIDTH-1] ? SAT_N : SAT_P;
    else     res = sum;
`else
    res = sum;
`endif
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin sharing of one add/subtract core between two valid/ready requesters.
// Build option: ADDSUB_SATURATE_EN clamps overflowed results (see addsub_core).
//
// state | meaning
// IDLE  | waiting for a request; ready offered to the granted requester
// EXEC  | core evaluates latched operands; response registers load
// RESP  | rsp_valid high, held until rsp_ready
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_res,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] ovf_cnt
);

  state_t           state, state_nxt;
  logic             last_grant;
  logic             grant_id;
  logic             hs;
  logic [WIDTH-1:0] op_a, op_b;
  logic             op_op, op_id;
  logic [WIDTH-1:0] core_res;
  logic             core_cout, core_ovf;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (op_a),
    .b    (op_b),
    .op   (op_op),
    .res  (core_res),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  // A lone requester wins outright; on a tie the one not served last wins.
  always_comb begin
    if (req0_valid && req1_valid) grant_id = ~last_grant;
    else                          grant_id = req1_valid;
    hs = (state == IDLE) && !rst && (req0_valid || req1_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = hs && !grant_id;
    req1_ready = hs && grant_id;
    busy       = (state != IDLE);
    rsp_valid  = (state == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_op      <= 1'b0;
      op_id      <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_res    <= '0;
      rsp_cout   <= 1'b0;
      rsp_ovf    <= 1'b0;
      ovf_cnt    <= '0;
    end else begin
      if (hs) begin
        op_a       <= grant_id ? req1_a  : req0_a;
        op_b       <= grant_id ? req1_b  : req0_b;
        op_op      <= grant_id ? req1_op : req0_op;
        op_id      <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        rsp_id   <= op_id;
        rsp_res  <= core_res;
        rsp_cout <= core_cout;
        rsp_ovf  <= core_ovf;
        if (core_ovf && (ovf_cnt != {CNT_W{1'b1}})) ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Self-checking bench: directed and random traffic against an arithmetic/timing model.
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_op, req1_op, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;

  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_cout, rsp_ovf, busy;
  logic [7:0] rsp_res, ovf_cnt;
  logic       s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_cout, s_rsp_ovf, s_busy;
  logic [7:0] s_rsp_res;
  logic [1:0] s_ovf_cnt;

  int vectors = 0;
  int miscompares = 0;

`ifdef ADDSUB_SATURATE_EN
  localparam logic [7:0] E_100P100 = 8'h7F;
  localparam logic [7:0] E_80M1    = 8'h80;
`else
  localparam logic [7:0] E_100P100 = 8'hC8;
  localparam logic [7:0] E_80M1    = 8'h7F;
`endif

  always #5 clk = ~clk;

  addsub_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_res(rsp_res),
    .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .busy(busy), .ovf_cnt(ovf_cnt)
  );

  addsub_arbiter #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(s_req1_ready),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id), .rsp_res(s_rsp_res),
    .rsp_cout(s_rsp_cout), .rsp_ovf(s_rsp_ovf), .busy(s_busy), .ovf_cnt(s_ovf_cnt)
  );

  // Reference model: one operation in flight, responding two cycles after its grant.
  bit       m_pending;
  int       m_age;
  bit       m_last;
  bit [7:0] m_a, m_b;
  bit       m_op, m_id;
  int       m_cnt8, m_cnt2;
  bit       hs0, hs1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, res} from plain integer arithmetic.
  function automatic logic [9:0] ref_op(input logic [7:0] a, input logic [7:0] b, input logic op);
    int full, sa, sb, s;
    logic [7:0] r;
    logic c, v;
    sa = $signed(a);
    sb = $signed(b);
    if (!op) begin full = int'(a) + int'(b);       s = sa + sb; end
    else     begin full = int'(a) - int'(b) + 256; s = sa - sb; end
    c = (full >= 256);
    r = full[7:0];
    v = (s > 127) || (s < -128);
`ifdef ADDSUB_SATURATE_EN
    if (v) r = (s > 127) ? 8'h7F : 8'h80;
`endif
    return {v, c, r};
  endfunction

  task automatic step();
    logic g, gid, e_r0, e_r1, e_rv, v0, v1, rr;
    logic [7:0] a0, b0, a1, b1;
    logic o0, o1;
    logic [9:0] r;
    #1;
    v0 = req0_valid; v1 = req1_valid; rr = rsp_ready;
    a0 = req0_a; b0 = req0_b; o0 = req0_op;
    a1 = req1_a; b1 = req1_b; o1 = req1_op;
    g    = !m_pending && (v0 || v1);
    gid  = (v0 && v1) ? !m_last : v1;
    e_r0 = g && !gid;
    e_r1 = g && gid;
    e_rv = m_pending && (m_age >= 2);
    chk("req0_ready", req0_ready, e_r0);
    chk("req1_ready", req1_ready, e_r1);
    chk("ready_excl", req0_ready & req1_ready, 0);
    chk("busy", busy, m_pending);
    chk("rsp_valid", rsp_valid, e_rv);
    chk("s_req0_ready", s_req0_ready, e_r0);
    chk("s_req1_ready", s_req1_ready, e_r1);
    chk("s_busy", s_busy, m_pending);
    chk("s_rsp_valid", s_rsp_valid, e_rv);
    if (e_rv) begin
      r = ref_op(m_a, m_b, m_op);
      chk("rsp_res", rsp_res, r[7:0]);
      chk("rsp_cout", rsp_cout, r[8]);
      chk("rsp_ovf", rsp_ovf, r[9]);
      chk("rsp_id", rsp_id, m_id);
      chk("s_rsp_res", s_rsp_res, r[7:0]);
      chk("s_rsp_cout", s_rsp_cout, r[8]);
      chk("s_rsp_ovf", s_rsp_ovf, r[9]);
      chk("s_rsp_id", s_rsp_id, m_id);
    end
    chk("ovf_cnt", ovf_cnt, m_cnt8);
    chk("s_ovf_cnt", s_ovf_cnt, m_cnt2);
    @(posedge clk);
    hs0 = e_r0;
    hs1 = e_r1;
    if (e_rv && rr) m_pending = 1'b0;
    else if (m_pending) begin
      if (m_age == 1) begin
        r = ref_op(m_a, m_b, m_op);
        if (r[9]) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3)   m_cnt2++;
        end
      end
      m_age++;
    end
    if (g) begin
      m_pending = 1'b1;
      m_age     = 1;
      m_id      = gid;
      m_last    = gid;
      m_a  = gid ? a1 : a0;
      m_b  = gid ? b1 : b0;
      m_op = gid ? o1 : o0;
    end
    #1;
  endtask

  task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b, input bit op);
    int n;
    if (id) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op; end
    else    begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op; end
    hs0 = 1'b0; hs1 = 1'b0;
    n = 0;
    while (!(id ? hs1 : hs0) && n < 20) begin step(); n++; end
    chk("granted", id ? hs1 : hs0, 1);
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    n = 0;
    while (!(m_pending && m_age >= 2) && n < 10) begin step(); n++; end
    chk("resp_reached", rsp_valid, 1);
  endtask

  task automatic model_reset();
    m_pending = 1'b0; m_age = 0; m_last = 1'b1;
    m_cnt8 = 0; m_cnt2 = 0;
  endtask

  initial begin
    int done, n;
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_res", rsp_res, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_cout_ovf", {rsp_cout, rsp_ovf}, 0);
    chk("rst_ovf_cnt", ovf_cnt, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;

    // Directed arithmetic cases
    run_op(0, 8'd50, 8'd10, 1'b1);
    chk("sub_res", rsp_res, 8'd40);
    chk("sub_cout", rsp_cout, 1);
    chk("sub_ovf", rsp_ovf, 0);
    chk("sub_id", rsp_id, 0);
    step(); step();
    run_op(1, 8'd100, 8'd100, 1'b0);
    chk("ovf_add_res", rsp_res, E_100P100);
    chk("ovf_add_flag", rsp_ovf, 1);
    chk("ovf_add_cnt", ovf_cnt, 1);
    chk("ovf_add_id", rsp_id, 1);
    step();
    run_op(0, 8'h80, 8'h01, 1'b1);
    chk("ovf_sub_res", rsp_res, E_80M1);
    chk("ovf_sub_flag", rsp_ovf, 1);
    chk("ovf_sub_cnt", ovf_cnt, 2);
    step();
    run_op(0, 8'h96, 8'h01, 1'b0);
    chk("neg_add_res", rsp_res, 8'h97);
    chk("neg_add_ovf", rsp_ovf, 0);
    chk("neg_add_cout", rsp_cout, 0);
    step();

    // Round-robin with both requesters continuously valid
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom);
    req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom);
    done = 0;
    for (int c = 0; c < 40 && done < 6; c++) begin
      step();
      if (hs0) begin done++; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom); end
      if (hs1) begin done++; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom); end
    end
    chk("rr_ops", done, 6);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step();

    // Backpressure with requests waiting
    rsp_ready = 1'b0;
    run_op(1, 8'($urandom), 8'($urandom), 1'($urandom));
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (10) step();
    rsp_ready = 1'b1;
    repeat (3) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) step();

    // Asynchronous reset while an operation executes
    req1_valid = 1'b1; req1_a = 8'd100; req1_b = 8'd100; req1_op = 1'b0;
    hs1 = 1'b0; n = 0;
    while (!hs1 && n < 20) begin step(); n++; end
    chk("mid_granted", hs1, 1);
    req1_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_ovf_cnt", ovf_cnt, 0);
    chk("mid_rst_rsp_res", rsp_res, 0);
    chk("mid_rst_s_ovf_cnt", s_ovf_cnt, 0);
    model_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    repeat (4) step();
    run_op(0, 8'd50, 8'd10, 1'b1);
    chk("post_rst_res", rsp_res, 8'd40);
    chk("post_rst_id", rsp_id, 0);
    step();

    // Counter saturation on the narrow-counter instance
    for (int k = 0; k < 5; k++) begin
      run_op(1'(k), 8'd100, 8'd100, 1'b0);
      step();
    end
    chk("sat_cnt2", s_ovf_cnt, 3);
    chk("sat_cnt8", ovf_cnt, 5);

    // Random traffic
    for (int c = 0; c < 300; c++) begin
      req0_valid = 1'($urandom); req1_valid = 1'($urandom);
      req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = 1'($urandom);
      req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = 1'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
